// File: rtl/rope_pkg.sv
// Shared types and fixed-point helpers for the rope physics scheduler slice.
package rope_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    LAUNCH,
    WAIT,
    PUBLISH
  } state_e;

  localparam int unsigned POS_W     = 32;
  localparam int unsigned PIX_W     = 10;
  localparam int unsigned FRAC_BITS = 12;

  // Pixel coordinate to unsigned fixed point with `frac` fractional bits.
  function automatic logic [POS_W-1:0] pix_to_fp(input logic [PIX_W-1:0] pix,
                                                 input int unsigned      frac);
    return POS_W'(pix) << frac;
  endfunction

endpackage

// File: rtl/rope_done_collector.sv
// Sticky per-pass done collector with a per-pass watchdog counter.
module rope_done_collector #(
  parameter int unsigned CORES   = 4,
  parameter int unsigned TIMEOUT = 1023,
  localparam int unsigned WDW    = $clog2(TIMEOUT + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             active_i,
  input  logic [CORES-1:0] core_done_i,
  output logic             all_done_o,
  output logic             timeout_o
);

  logic [CORES-1:0] seen_q;
  logic [WDW-1:0]   wd_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      seen_q <= '0;
      wd_q   <= '0;
    end else if (clear_i) begin
      seen_q <= '0;
      wd_q   <= '0;
    end else if (active_i) begin
      seen_q <= seen_q | core_done_i;
      wd_q   <= wd_q + WDW'(1);
    end
  end

  // A done arriving in the completing cycle counts, hence the OR with the live input.
  assign all_done_o = active_i & (&(seen_q | core_done_i));
  assign timeout_o  = active_i & (wd_q >= WDW'(TIMEOUT - 1));

endmodule

// File: rtl/rope_step_scheduler.sv
// Frame sequencer: latch mouse, one integrate pass, ITERS constraint passes, publish.
module rope_step_scheduler #(
  parameter int unsigned CORES     = 4,
  parameter int unsigned ITERS     = 8,
  parameter int unsigned TIMEOUT   = 1023,
  parameter int unsigned FRAC_BITS = 12,
  localparam int unsigned IW       = (ITERS > 1) ? $clog2(ITERS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             frame_tick,
  input  logic [9:0]       in_mouse_x,
  input  logic [9:0]       in_mouse_y,
  input  logic             mouse_valid,
  input  logic [CORES-1:0] core_done,
  output logic             step_start,
  output logic             phase,
  output logic [IW-1:0]    iter_idx,
  output logic [31:0]      mouse_x_fp,
  output logic [31:0]      mouse_y_fp,
  output logic             publish,
  output logic             busy,
  output logic             fault,
  output logic [7:0]       overrun_cnt
);

  import rope_pkg::*;

  state_e           state_q, state_d;
  logic             phase_q, phase_d;
  logic [IW-1:0]    iter_q, iter_d;
  logic [POS_W-1:0] mx_q, mx_d, my_q, my_d;
  logic             fault_q, fault_d;
  logic [7:0]       ovr_q, ovr_d;
  logic             all_done, timeout;

  rope_done_collector #(
    .CORES  (CORES),
    .TIMEOUT(TIMEOUT)
  ) u_collector (
    .clk_i      (clk),
    .rst_ni     (reset),
    .clear_i    (state_q == LAUNCH),
    .active_i   (state_q == WAIT),
    .core_done_i(core_done),
    .all_done_o (all_done),
    .timeout_o  (timeout)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      phase_q <= 1'b0;
      iter_q  <= '0;
      mx_q    <= '0;
      my_q    <= '0;
      fault_q <= 1'b0;
      ovr_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      iter_q  <= iter_d;
      mx_q    <= mx_d;
      my_q    <= my_d;
      fault_q <= fault_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    iter_d  = iter_q;
    mx_d    = mx_q;
    my_d    = my_q;
    fault_d = fault_q;
    ovr_d   = ovr_q;

    if (frame_tick && (state_q != IDLE) && (ovr_q != 8'hFF)) ovr_d = ovr_q + 8'd1;

    unique case (state_q)
      IDLE: if (frame_tick && enable) state_d = LATCH;
      LATCH: begin
        if (mouse_valid) begin
          mx_d = pix_to_fp(in_mouse_x, FRAC_BITS);
          my_d = pix_to_fp(in_mouse_y, FRAC_BITS);
        end
        phase_d = 1'b0;
        iter_d  = '0;
        state_d = LAUNCH;
      end
      LAUNCH: state_d = WAIT;
      WAIT: begin
        // Completion takes priority over a watchdog expiry in the same cycle.
        if (all_done) begin
          if (!phase_q) begin
            phase_d = 1'b1;
            iter_d  = '0;
            state_d = LAUNCH;
          end else if (iter_q == IW'(ITERS - 1)) begin
            state_d = PUBLISH;
          end else begin
            iter_d  = iter_q + IW'(1);
            state_d = LAUNCH;
          end
        end else if (timeout) begin
          fault_d = 1'b1;
          state_d = IDLE;
        end
      end
      PUBLISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign step_start  = (state_q == LAUNCH);
  assign publish     = (state_q == PUBLISH);
  assign busy        = (state_q != IDLE);
  assign phase       = phase_q;
  assign iter_idx    = iter_q;
  assign mouse_x_fp  = mx_q;
  assign mouse_y_fp  = my_q;
  assign fault       = fault_q;
  assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_rope_step_scheduler.sv
// Directed table-driven bench for rope_step_scheduler with hand-computed expectations.
module tb_rope_step_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        frame_tick = 1'b0;
  logic [9:0]  in_mouse_x = '0;
  logic [9:0]  in_mouse_y = '0;
  logic        mouse_valid = 1'b0;
  logic [3:0]  core_done = '0;
  logic        step_start, phase, publish, busy, fault;
  logic [2:0]  iter_idx;
  logic [31:0] mouse_x_fp, mouse_y_fp;
  logic [7:0]  overrun_cnt;

  int errors = 0;
  int checks = 0;

  rope_step_scheduler #(
    .CORES(4), .ITERS(8), .TIMEOUT(1023), .FRAC_BITS(12)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .frame_tick(frame_tick),
    .in_mouse_x(in_mouse_x), .in_mouse_y(in_mouse_y), .mouse_valid(mouse_valid),
    .core_done(core_done), .step_start(step_start), .phase(phase),
    .iter_idx(iter_idx), .mouse_x_fp(mouse_x_fp), .mouse_y_fp(mouse_y_fp),
    .publish(publish), .busy(busy), .fault(fault), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Starts at a negedge with the DUT idle; ticks once, answers each launch with
  // per-core done delays, and returns once busy drops.
  task automatic do_frame(input logic [9:0] x, input logic [9:0] y, input logic v,
                          input int d0, input int d1, input int d2, input int d3,
                          input int never_core, input int exp_gap,
                          output int starts, output int pub_cyc, output int end_cyc);
    int d[4];
    int last_l;
    int n;
    bit done;
    d = '{d0, d1, d2, d3};
    starts = 0; pub_cyc = -1; end_cyc = -1; last_l = -100; n = 0; done = 0;
    enable = 1'b1; frame_tick = 1'b1;
    in_mouse_x = x; in_mouse_y = y; mouse_valid = v; core_done = '0;
    while (!done && n < 1200) begin
      @(negedge clk);
      n++;
      frame_tick = 1'b0;
      if (step_start) begin
        chk("launch_phase", {31'd0, phase}, (starts > 0) ? 32'd1 : 32'd0);
        chk("launch_iter", {29'd0, iter_idx}, (starts > 0) ? 32'(starts - 1) : 32'd0);
        if (exp_gap > 0 && starts > 0) chk("launch_gap", 32'(n - last_l), 32'(exp_gap));
        last_l = n;
        starts++;
      end
      if (publish) pub_cyc = n;
      if (!busy) begin
        end_cyc = n;
        done = 1;
      end
      core_done = '0;
      for (int c = 0; c < 4; c++)
        if (n == last_l + d[c] && !(c == never_core && starts == 1)) core_done[c] = 1'b1;
    end
    core_done = '0;
    chk("frame_end", {31'd0, done}, 32'd1);
  endtask

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        v;
    int          d0, d1, d2, d3;
    int          gap;
    logic [31:0] ex, ey;
    int          starts;
    int          pub;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int starts, pub_cyc, end_cyc;
    bit seen;

    tbl[0] = '{10'd320,  10'd240,  1'b1, 1, 1, 1, 1, 2, 32'h0014_0000, 32'h000F_0000, 9, 20};
    tbl[1] = '{10'd100,  10'd50,   1'b1, 1, 1, 1, 1, 2, 32'h0006_4000, 32'h0003_2000, 9, 20};
    tbl[2] = '{10'd500,  10'd77,   1'b0, 1, 1, 1, 1, 2, 32'h0006_4000, 32'h0003_2000, 9, 20};
    tbl[3] = '{10'd1023, 10'd0,    1'b1, 1, 3, 3, 7, 8, 32'h003F_F000, 32'h0000_0000, 9, 74};
    tbl[4] = '{10'd5,    10'd1023, 1'b1, 2, 2, 2, 2, 3, 32'h0000_5000, 32'h003F_F000, 9, 29};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_mouse_x", mouse_x_fp, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_overrun", {24'd0, overrun_cnt}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      do_frame(tbl[i].x, tbl[i].y, tbl[i].v, tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].d3,
               -1, tbl[i].gap, starts, pub_cyc, end_cyc);
      chk("tbl_starts", 32'(starts), 32'(tbl[i].starts));
      chk("tbl_publish_cycle", 32'(pub_cyc), 32'(tbl[i].pub));
      chk("tbl_mouse_x", mouse_x_fp, tbl[i].ex);
      chk("tbl_mouse_y", mouse_y_fp, tbl[i].ey);
    end

    // Watchdog: core 2 silent in the integrate pass
    do_frame(10'd10, 10'd20, 1'b1, 1, 1, 1, 1, 2, 0, starts, pub_cyc, end_cyc);
    chk("wd_starts", 32'(starts), 32'd1);
    chk("wd_no_publish", 32'(pub_cyc), 32'hFFFF_FFFF);
    chk("wd_end_cycle", 32'(end_cyc), 32'd1026);
    chk("wd_fault", {31'd0, fault}, 32'd1);
    do_frame(10'd320, 10'd240, 1'b1, 1, 1, 1, 1, -1, 2, starts, pub_cyc, end_cyc);
    chk("post_wd_publish", 32'(pub_cyc), 32'd20);
    chk("post_wd_fault", {31'd0, fault}, 32'd1);

    // Overrun: idle ticks with enable low are not counted
    enable = 1'b0; frame_tick = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_tick_busy", {31'd0, busy}, 32'd0);
    chk("idle_tick_overrun", {24'd0, overrun_cnt}, 32'd0);
    enable = 1'b1; in_mouse_x = 10'd7; in_mouse_y = 10'd9; mouse_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    in_mouse_x = 10'd900; in_mouse_y = 10'd900;
    chk("ovr_busy", {31'd0, busy}, 32'd1);
    chk("ovr_first", {24'd0, overrun_cnt}, 32'd1);
    repeat (99) @(negedge clk);
    chk("ovr_100", {24'd0, overrun_cnt}, 32'd100);
    repeat (200) @(negedge clk);
    chk("ovr_saturate", {24'd0, overrun_cnt}, 32'd255);
    frame_tick = 1'b0; enable = 1'b0; core_done = '1;
    seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (publish) seen = 1;
    end
    core_done = '0;
    chk("enable_low_publish", {31'd0, seen}, 32'd1);
    chk("ovr_mouse_x", mouse_x_fp, 32'h0000_7000);
    chk("ovr_mouse_y", mouse_y_fp, 32'h0000_9000);
    @(negedge clk);

    // Async reset in the WAIT of pass 4
    enable = 1'b1; frame_tick = 1'b1; in_mouse_x = 10'd320; in_mouse_y = 10'd240;
    mouse_valid = 1'b1;
    for (int n = 1; n <= 11; n++) begin
      @(negedge clk);
      frame_tick = 1'b0;
      core_done = (n >= 3 && n < 11 && (n % 2) == 1) ? 4'hF : 4'h0;
    end
    chk("pre_rst_iter", {29'd0, iter_idx}, 32'd3);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_step_start", {31'd0, step_start}, 32'd0);
    chk("arst_phase_iter", {28'd0, phase, iter_idx}, 32'd0);
    chk("arst_mouse", mouse_x_fp | mouse_y_fp, 32'd0);
    chk("arst_fault_ovr", {23'd0, fault, overrun_cnt}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    do_frame(10'd320, 10'd240, 1'b1, 1, 1, 1, 1, -1, 2, starts, pub_cyc, end_cyc);
    chk("post_rst_starts", 32'(starts), 32'd9);
    chk("post_rst_publish", 32'(pub_cyc), 32'd20);
    chk("post_rst_mouse_x", mouse_x_fp, 32'h0014_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
